// File: rtl/box_engine.sv
// rtl/box_engine.sv - multi-box hit tester with frame-committed box registers
// Two-stage pipeline: containment vector, then priority/any/collision reduction.
module box_engine #(
    parameter int N_BOXES = 3,
    parameter int W       = 10,
    parameter int IDX_W   = (N_BOXES > 1) ? $clog2(N_BOXES) : 1
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    input  logic [W-1:0]       X_pix,
    input  logic [W-1:0]       Y_pix,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [W-1:0]       wr_x,
    input  logic [W-1:0]       wr_y,
    input  logic [W-1:0]       wr_w,
    input  logic [W-1:0]       wr_h,
    input  logic               wr_vis,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [N_BOXES-1:0] hit_vec,
    output logic [N_BOXES-1:0] collide_vec,
    output logic               collide_valid
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] w;
        logic [W-1:0] h;
        logic         vis;
    } box_t;

    box_t               shadow_q [N_BOXES];
    box_t               active_q [N_BOXES];
    box_t               wr_box;
    logic [N_BOXES-1:0] s1_vec_d;
    logic [N_BOXES-1:0] s1_vec_q;
    logic [N_BOXES-1:0] acc_q;
    logic [N_BOXES-1:0] collide_vec_q;
    logic               collide_valid_q;
    logic               hit_q;
    logic [IDX_W-1:0]   hit_idx_d;
    logic [IDX_W-1:0]   hit_idx_q;
    logic [N_BOXES-1:0] hit_vec_q;
    logic               multi_hit;

    assign wr_box = '{x: wr_x, y: wr_y, w: wr_w, h: wr_h, vis: wr_vis};

    // Right/bottom edges carry one extra bit so a box past the screen edge clips
    for (genvar g = 0; g < N_BOXES; g++) begin : g_box
        logic [W:0] x_end;
        logic [W:0] y_end;
        assign x_end = {1'b0, active_q[g].x} + {1'b0, active_q[g].w};
        assign y_end = {1'b0, active_q[g].y} + {1'b0, active_q[g].h};
        assign s1_vec_d[g] = active_q[g].vis
                           && (X_pix >= active_q[g].x) && ({1'b0, X_pix} < x_end)
                           && (Y_pix >= active_q[g].y) && ({1'b0, Y_pix} < y_end);
    end

    always_comb begin
        hit_idx_d = '0;
        for (int i = N_BOXES - 1; i >= 0; i--) begin
            if (s1_vec_q[i]) hit_idx_d = IDX_W'(i);
        end
    end

    // Clearing the lowest set bit leaves something only when two or more boxes overlap
    assign multi_hit = |(s1_vec_q & (s1_vec_q - N_BOXES'(1)));

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BOXES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            s1_vec_q        <= '0;
            acc_q           <= '0;
            collide_vec_q   <= '0;
            collide_valid_q <= 1'b0;
            hit_q           <= 1'b0;
            hit_idx_q       <= '0;
            hit_vec_q       <= '0;
        end else begin
            for (int i = 0; i < N_BOXES; i++) begin
                if (frame_start) active_q[i] <= shadow_q[i];
                if (wr_en && wr_idx == IDX_W'(i)) shadow_q[i] <= wr_box;
            end
            s1_vec_q        <= s1_vec_d;
            hit_vec_q       <= s1_vec_q;
            hit_q           <= |s1_vec_q;
            hit_idx_q       <= hit_idx_d;
            collide_valid_q <= frame_start;
            if (frame_start) begin
                collide_vec_q <= acc_q;
                acc_q         <= '0;
            end else if (multi_hit) begin
                acc_q <= acc_q | s1_vec_q;
            end
        end
    end

    assign hit           = hit_q;
    assign hit_idx       = hit_idx_q;
    assign hit_vec       = hit_vec_q;
    assign collide_vec   = collide_vec_q;
    assign collide_valid = collide_valid_q;

endmodule

// File: tb/tb_box_engine.sv
// tb/tb_box_engine.sv - randomized and directed bench for box_engine
module tb_box_engine;

    localparam int N = 3;

    logic       pixel_clk = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] X_pix, Y_pix, wr_x, wr_y, wr_w, wr_h;
    logic       frame_start, wr_en, wr_vis;
    logic [1:0] wr_idx;
    logic [2:0] wr_idx8;
    logic       hit, collide_valid;
    logic [1:0] hit_idx;
    logic [2:0] hit_vec, collide_vec;
    logic       hit8, collide_valid8;
    logic [2:0] hit_idx8;
    logic [7:0] hit_vec8, collide_vec8;

    box_engine dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .X_pix(X_pix), .Y_pix(Y_pix),
        .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .wr_vis(wr_vis),
        .hit(hit), .hit_idx(hit_idx), .hit_vec(hit_vec),
        .collide_vec(collide_vec), .collide_valid(collide_valid)
    );

    box_engine #(.N_BOXES(8)) dut8 (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .X_pix(X_pix), .Y_pix(Y_pix),
        .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx8),
        .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .wr_vis(wr_vis),
        .hit(hit8), .hit_idx(hit_idx8), .hit_vec(hit_vec8),
        .collide_vec(collide_vec8), .collide_valid(collide_valid8)
    );

    always #5 pixel_clk = ~pixel_clk;

    int tests = 0;
    int fails = 0;
    int hit_count = 0;
    bit count_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: box lists and what the outputs must show, in integer terms
    typedef struct {
        int x; int y; int w; int h; bit vis;
    } mbox_t;

    mbox_t      m_sh [N];
    mbox_t      m_act[N];
    bit [N-1:0] m_pipe1, m_out, m_acc, m_col;
    bit         m_cv;

    function automatic bit [N-1:0] covered(input int px, input int py);
        bit [N-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i].vis && px >= m_act[i].x && px < m_act[i].x + m_act[i].w
                && py >= m_act[i].y && py < m_act[i].y + m_act[i].h)
                r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int lowest(input bit [N-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_sh[i]  <= '{0, 0, 0, 0, 1'b0};
                m_act[i] <= '{0, 0, 0, 0, 1'b0};
            end
            m_pipe1 <= '0; m_out <= '0; m_acc <= '0; m_col <= '0; m_cv <= 1'b0;
        end else begin
            m_pipe1 <= covered(int'(X_pix), int'(Y_pix));
            m_out   <= m_pipe1;
            m_cv    <= frame_start;
            if (frame_start) begin
                m_col <= m_acc;
                m_acc <= '0;
                for (int i = 0; i < N; i++) m_act[i] <= m_sh[i];
            end else if ($countones(m_pipe1) >= 2) begin
                m_acc <= m_acc | m_pipe1;
            end
            if (wr_en && int'(wr_idx) < N)
                m_sh[wr_idx] <= '{int'(wr_x), int'(wr_y), int'(wr_w), int'(wr_h), wr_vis};
        end
    end

    always @(negedge pixel_clk) begin
        if (reset_n) begin
            check("hit", hit, |m_out);
            check("hit_idx", hit_idx, lowest(m_out));
            check("hit_vec", hit_vec, m_out);
            check("collide_vec", collide_vec, m_col);
            check("collide_valid", collide_valid, m_cv);
            if (count_en && hit) hit_count++;
        end
    end

    task automatic step();
        @(negedge pixel_clk);
    endtask

    task automatic wr(input int idx, input int x, input int y, input int w, input int h, input bit vis);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_idx8 = 3'(idx);
        wr_x = 10'(x); wr_y = 10'(y); wr_w = 10'(w); wr_h = 10'(h); wr_vis = vis;
        step();
        wr_en = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Present one pixel, park off-screen, and return when its result is on the outputs
    task automatic probe(input int x, input int y);
        X_pix = 10'(x); Y_pix = 10'(y);
        step();
        X_pix = 10'd1000; Y_pix = 10'd1000;
        step();
    endtask

    initial begin
        X_pix = 10'd1000; Y_pix = 10'd1000; frame_start = 1'b0; wr_en = 1'b0;
        wr_idx = '0; wr_idx8 = '0; wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0; wr_vis = 1'b0;
        repeat (3) step();
        check("reset_hit", hit, 0);
        check("reset_collide_valid", collide_valid, 0);
        reset_n = 1'b1;
        step();

        // Single box raster scan
        wr(0, 50, 50, 15, 15, 1'b1);
        fs();
        count_en = 1'b1;
        for (int y = 45; y <= 70; y++)
            for (int x = 40; x <= 70; x++) begin
                X_pix = 10'(x); Y_pix = 10'(y);
                step();
            end
        X_pix = 10'd1000; Y_pix = 10'd1000;
        step(); step();
        count_en = 1'b0;
        check("scan_hit_count", hit_count, 225);
        probe(64, 64); check("corner_in", hit, 1);
        probe(65, 50); check("x_edge_out", hit, 0);
        probe(50, 49); check("y_edge_out", hit, 0);

        // Overlap, priority and collision report
        wr(0, 10, 10, 20, 20, 1'b1);
        wr(1, 20, 20, 20, 20, 1'b1);
        fs();
        probe(25, 25);
        check("ovl_hit_idx", hit_idx, 0);
        check("ovl_hit_vec", hit_vec, 3'b011);
        fs();
        check("collide_vec", collide_vec, 3'b011);
        check("collide_valid_pulse", collide_valid, 1);
        step();
        check("collide_valid_drop", collide_valid, 0);
        frame_start = 1'b1; step(); step(); frame_start = 1'b0;
        check("double_fs_vec", collide_vec, 0);
        check("double_fs_valid", collide_valid, 1);

        // Mid-frame write and write coincident with frame_start
        wr(1, 100, 20, 20, 20, 1'b1);
        probe(100, 20); check("midframe_no_effect", hit, 0);
        fs();
        probe(100, 20);
        check("new_frame_hit_idx", hit_idx, 1);
        check("new_frame_hit_vec", hit_vec, 3'b010);
        wr_en = 1'b1; wr_idx = 2'd1; wr_idx8 = 3'd1;
        wr_x = 10'd200; wr_y = 10'd20; wr_w = 10'd20; wr_h = 10'd20; wr_vis = 1'b1;
        frame_start = 1'b1;
        step();
        wr_en = 1'b0; frame_start = 1'b0;
        probe(100, 20); check("coincident_old_kept", hit_vec, 3'b010);
        probe(200, 20); check("coincident_not_yet", hit, 0);
        fs();
        probe(200, 20); check("coincident_applied", hit_vec, 3'b010);

        // Right-edge clipping and zero-width box
        wr(2, 1020, 0, 10, 10, 1'b1);
        wr(0, 0, 0, 0, 10, 1'b1);
        fs();
        probe(1023, 5);
        check("clip_hit_vec", hit_vec, 3'b100);
        check("clip_hit_idx", hit_idx, 2);
        probe(1019, 5); check("clip_left_out", hit, 0);
        for (int c = 0; c <= 5; c++) begin
            probe(c, 5);
            check("no_wrap_or_w0", hit, 0);
        end

        // Collision, then asynchronous reset mid-scan
        wr(0, 1015, 0, 10, 10, 1'b1);
        fs();
        X_pix = 10'd1021; Y_pix = 10'd5;
        step(); step(); step();
        fs();
        check("pre_reset_collide", collide_vec, 3'b101);
        check("pre_reset_hit_idx", hit_idx, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_hit", hit, 0);
        check("async_reset_hit_vec", hit_vec, 0);
        check("async_reset_collide", collide_vec, 0);
        step();
        reset_n = 1'b1;
        step(); step(); step();
        check("post_reset_no_hit", hit, 0);
        wr(2, 1020, 0, 10, 10, 1'b1);
        step(); step();
        check("write_without_commit", hit, 0);
        fs();
        step(); step();
        check("after_commit_hit_idx", hit_idx, 2);
        X_pix = 10'd1000; Y_pix = 10'd1000;

        // Out-of-range index on the 3-box build; box7 on the 8-box build
        wr_en = 1'b1; wr_idx = 2'd3; wr_idx8 = 3'd7;
        wr_x = 10'd0; wr_y = 10'd0; wr_w = 10'd4; wr_h = 10'd4; wr_vis = 1'b1;
        step();
        wr_en = 1'b0;
        fs();
        probe(2, 2);
        check("oob_index_ignored", hit, 0);
        check("n8_hit", hit8, 1);
        check("n8_hit_idx", hit_idx8, 7);
        check("n8_hit_vec", hit_vec8, 8'h80);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            frame_start = ($urandom_range(0, 99) < 3);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_idx = 2'($urandom_range(0, 3));
            wr_idx8 = {1'b0, wr_idx};
            wr_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 40));
            wr_y = 10'($urandom_range(0, 40));
            wr_w = 10'($urandom_range(0, 25));
            wr_h = 10'($urandom_range(0, 25));
            wr_vis = ($urandom_range(0, 3) != 0);
            X_pix = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 50));
            Y_pix = 10'($urandom_range(0, 50));
            step();
        end
        frame_start = 1'b0; wr_en = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/box_engine.md
# box_engine

Parametrised multi-box renderer, successor to the single-box hit detector in the Pong video path. Holds position/size for N_BOXES rectangles (paddles, ball, net segments) in double-buffered registers committed at frame start, and runs a 2-stage pipelined hit test against the current pixel. Outputs the winning box index (lowest index has priority) and per-box per-frame overlap flags for game-logic collision detection. Sits between the VGA timing generator and the colour mux.

## Interface
- N_BOXES, default 3: number of boxes; range 1..16
- W, default 10: coordinate width in bits
- IDX_W, default $clog2(N_BOXES) (min 1): index width
- pixel_clk  input  1  pixel clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- X_pix  input  W  current pixel column
- Y_pix  input  W  current pixel row
- frame_start  input  1  one-cycle pulse, asserted during vertical blanking
- wr_en  input  1  write strobe into shadow registers
- wr_idx  input  IDX_W  box being written; indices >= N_BOXES ignored
- wr_x, wr_y  input  W each  box top-left corner
- wr_w, wr_h  input  W each  box width / height in pixels
- wr_vis  input  1  box visible flag
- hit  output  1  current (delayed) pixel inside at least one visible box
- hit_idx  output  IDX_W  lowest-index box containing the pixel; 0 when hit=0
- hit_vec  output  N_BOXES  per-box containment, bit i = box i
- collide_vec  output  N_BOXES  bit i set if box i shared a pixel with any other box during the previous frame
- collide_valid  output  1  one-cycle pulse when collide_vec updates

## Operation
- Two register banks per box: shadow {x,y,w,h,vis} and active. wr_en writes shadow[wr_idx] on the clock edge.
- On frame_start: active <= shadow for all boxes. A write in the same cycle as frame_start lands in shadow only; the copy uses the pre-write shadow value (write visible in the following frame).
- Containment, box i: vis_i && (X_pix >= x_i) && (X_pix < x_i + w_i) && (Y_pix >= y_i) && (Y_pix < y_i + h_i). Half-open: box spans exactly w columns and h rows.
- Sums x+w and y+h computed at W+1 bits; no wrap. Box extending past 2^W-1 is clipped, never reappears at column 0.
- w=0 or h=0: box never hits.
- Stage 1: register raw containment vector s1_vec.
- Stage 2: hit_vec <= s1_vec; hit <= |s1_vec; hit_idx <= index of lowest set bit (0 if none).
- Collision accumulator acc[N_BOXES]: each cycle, if popcount(s1_vec) >= 2, acc |= s1_vec.
- On frame_start: collide_vec <= acc; acc <= 0; that cycle's s1 contribution discarded. collide_valid pulses the cycle after frame_start (coincident with collide_vec being readable).
- N_BOXES=1: collide_vec permanently 0.

## Timing
- Reset (reset_n low, asynchronous): shadow, active, s1_vec, acc, hit, hit_idx, hit_vec, collide_vec, collide_valid all 0. Outputs 0 within reset, independent of clock.
- Reset deassertion mid-frame: all boxes invisible until first frame_start after shadow is written.
- Pixel-to-output latency: 2 pixel_clk cycles; hit/hit_idx/hit_vec at edge N+2 reflect X_pix/Y_pix sampled at edge N.
- Active register change takes effect on pixels sampled the cycle after frame_start; visible on outputs 2 cycles later.
- frame_start on consecutive cycles: each is a full commit; second produces collide_vec=0 and a second collide_valid pulse.
- No handshake on writes; one write per cycle; back-to-back writes to same index: last wins.

## Test plan
- Box0 {x=50,y=50,w=15,h=15,vis=1}, frame_start, raster scan -> hit=1 exactly for X 50..64, Y 50..64 (225 pixels), 2 cycles after each sample; X=65 or Y=49 -> hit=0.
- Box0 {10,10,20,20}, Box1 {20,20,20,20}, both visible -> pixel (25,25): hit_idx=0, hit_vec=3'b011; next frame_start -> collide_vec=3'b011, collide_valid one pulse; box2 bit 0.
- Write Box1 x=100 mid-frame -> no change in current frame; after frame_start pixel (100,20) hits box1; write coincident with frame_start -> applied one frame later.
- Box2 {x=1020,w=10} with W=10 -> hits columns 1020..1023 only; column 0..5 never hit. w=0 box -> never hits.
- Assert reset_n low mid-scan with boxes hitting -> hit, hit_vec, collide_vec drop to 0 immediately; after release, no hits until new writes plus frame_start.
- N_BOXES=8 build, box7 only visible at (0,0,4,4) -> hit_idx=7 at pixel (2,2); wr_idx beyond range (N_BOXES=3, wr_idx=3) -> no register change.
